keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 hex keypad and debounces it, then emits one 4-bit key code per press. Accepted keys shift into a four-digit register whose outputs wire straight to the digit inputs of the seven-segment display block. It is the input-side counterpart of the display driver: it drives column strobes out and reads row lines back, and it feeds operands to the adder datapath.

## Interface
- SCAN_RATIO, 2048: clock cycles per column step; minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to accept a press or a release; minimum 1.
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- row  in  4  keypad rows, active-low, pulled up externally; row[r] low = key in row r of the strobed column
- column  out  4  column strobes, active-low, exactly one low at a time; column[c] low strobes column c
- key_code  out  4  last accepted key, hex value
- key_valid  out  1  one-cycle pulse when a key is accepted
- key_held  out  1  high from acceptance until release is debounced
- digit_1, digit_2, digit_3, digit_4  out  4 each  entered digits; digit_1 leftmost (oldest), digit_4 rightmost (newest)

## Operation
- Key map, (row r, column c) -> code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- Tick counter runs 0..SCAN_RATIO-1 and wraps. tick = (count == SCAN_RATIO-1).
- Column index col runs 0..3 and advances on each tick, wrapping 3 -> 0. column = ~(1 << col).
- row passes through a 2-flop synchronizer (reset value 4'b1111). Each tick evaluates the synchronized row against the current col, before col advances.
- Scan accumulation across cols 0..3:
  - Zero low rows in every column: result NONE.
  - Exactly one low row in exactly one column: result KEY(code).
  - Anything else (two rows low, or hits in two columns): result NONE.
  - The result is formed on the col-3 tick and the accumulator clears.
- FSM, updated only on col-3 ticks, using cnt (saturating) and cand:
  - IDLE: KEY(k) -> cand = k, cnt = 1. If DEBOUNCE_SCANS = 1, accept immediately; otherwise go to DEBOUNCE. NONE -> stay.
  - DEBOUNCE: KEY(cand) -> cnt++. When cnt reaches DEBOUNCE_SCANS, accept. NONE or a different key -> IDLE, cnt = 0.
  - Accept: state = PRESSED, key_code = cand, key_valid pulse, key_held = 1. Digits shift left: digit_1 <- digit_2 <- digit_3 <- digit_4 <- cand.
  - PRESSED: any KEY -> stay; no new accept, even for a different key. NONE -> RELEASE with cnt = 1, or go directly to IDLE if DEBOUNCE_SCANS = 1.
  - RELEASE: NONE -> cnt++. At DEBOUNCE_SCANS -> IDLE, key_held = 0. Any KEY -> PRESSED, cnt = 0.
- Reset, asynchronous and effective mid-scan or mid-debounce:
  - count = 0, col = 0, column = 4'b1110.
  - State IDLE, cnt = 0, cand = 0, accumulator cleared, synchronizer 4'b1111.
  - key_code = 0, key_valid = 0, key_held = 0, all digits = 0.
- All outputs are registered.

## Timing
- One scan = 4*SCAN_RATIO cycles.
- column changes on the clock edge where tick is high.
- key_valid is high for exactly the single cycle after the col-3 tick edge that completes the DEBOUNCE_SCANS-th matching scan.
- key_code and the digits update on that same edge.
- Press latency, from a stable press synchronized before col 0: DEBOUNCE_SCANS scans + 1 cycle.
- A press that begins mid-scan is missed or counted as NONE for that scan, adding up to one extra scan.
- key_held falls on the edge completing the DEBOUNCE_SCANS-th consecutive NONE scan.
- key_valid never pulses on consecutive cycles. At most one pulse per press/release cycle.

## Test plan
Benches use SCAN_RATIO = 4, DEBOUNCE_SCANS = 2 (scan = 16 cycles).
- Reset: assert reset, then release it. Required: column = 1110, all outputs 0. Column steps to 1101 after 4 cycles, 1011 after 8, 0111 after 12, and back to 1110 after 16.
- Single press of 5 (row1 low while column[1] low), held 100 cycles, then released. Required:
  - exactly one key_valid pulse, key_code = 5, digit_4 = 5, other digits 0;
  - key_held = 1 until two NONE scans after release, then 0.
- Sequence 1, 2, 3, A, each pressed 3 scans and released 3 scans. Required: 4 pulses; digit_1..digit_4 = 1, 2, 3, A. A fifth key 0 gives 2, 3, A, 0.
- Bounce: E pressed for one scan only, then released. Required: no key_valid, digits unchanged, key_held = 0.
- Multi-key cases:
  - 1 and 6 pressed together: no pulse.
  - 7 held, then 9 added mid-hold: one pulse only, key_code = 7.
- Reset asserted during DEBOUNCE, and again during PRESSED. Required: all outputs return to reset values immediately and column = 1110. Scanning resumes cleanly afterwards.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad column scanner with debounce and four-digit entry register
module keypad_scanner #(
    parameter int SCAN_RATIO     = 2048,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] column,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] digit_3,
    output logic [3:0] digit_4
);

    localparam int CW = (SCAN_RATIO > 1) ? $clog2(SCAN_RATIO) : 1;
    localparam int NW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(SCAN_RATIO - 1);
    localparam logic [NW-1:0] DEB_TARGET = NW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    logic [CW-1:0] count_q;
    logic [1:0]    col_q;
    logic [3:0]    column_q;
    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;
    logic          acc_hit_q;
    logic          acc_bad_q;
    logic [3:0]    acc_code_q;
    state_t        state_q;
    logic [NW-1:0] cnt_q;
    logic [3:0]    cand_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;
    logic [15:0]   digits_q;

    logic          tick;
    logic          scan_done;
    logic [1:0]    col_d;
    logic [3:0]    row_low;
    logic [2:0]    low_count;
    logic [1:0]    row_idx;
    logic          col_hit;
    logic          acc_hit_d;
    logic          acc_bad_d;
    logic [3:0]    acc_code_d;
    logic          scan_key;
    logic [NW-1:0] cnt_inc;
    logic          do_accept;

    // Row/column position to hex code, laid out as printed on the keypad.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    assign tick      = (count_q == LAST_COUNT);
    assign scan_done = tick && (col_q == 2'd3);
    assign col_d     = col_q + 2'd1;
    assign cnt_inc   = (cnt_q == DEB_TARGET) ? cnt_q : cnt_q + NW'(1);

    // Fold the current column's rows into the running scan result.
    always_comb begin
        row_low    = ~row_sync_q;
        low_count  = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
        // Only meaningful when exactly one row is low.
        row_idx    = {row_low[3] | row_low[2], row_low[3] | row_low[1]};
        col_hit    = (low_count == 3'd1);
        acc_hit_d  = acc_hit_q | col_hit;
        acc_bad_d  = acc_bad_q | (low_count > 3'd1) | (col_hit & acc_hit_q);
        acc_code_d = (col_hit && !acc_hit_q) ? key_map(row_idx, col_q) : acc_code_q;
        scan_key   = acc_hit_d & ~acc_bad_d;
    end

    // A press is accepted on the scan that completes the required run of matches.
    always_comb begin
        do_accept = 1'b0;
        if (scan_done && scan_key) begin
            if (state_q == S_IDLE) begin
                do_accept = (DEBOUNCE_SCANS == 1);
            end else if (state_q == S_DEBOUNCE && acc_code_d == cand_q) begin
                do_accept = (cnt_inc == DEB_TARGET);
            end
        end
    end

    // Tick counter and column strobe sequencing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            col_q    <= 2'd0;
            column_q <= 4'b1110;
        end else if (tick) begin
            count_q  <= '0;
            col_q    <= col_d;
            column_q <= ~(4'b0001 << col_d);
        end else begin
            count_q  <= count_q + CW'(1);
        end
    end

    // Two-flop synchronizer on the asynchronous row inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Scan accumulator: updated per column, cleared when a full scan completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_hit_q  <= 1'b0;
            acc_bad_q  <= 1'b0;
            acc_code_q <= 4'h0;
        end else if (scan_done) begin
            acc_hit_q  <= 1'b0;
            acc_bad_q  <= 1'b0;
            acc_code_q <= 4'h0;
        end else if (tick) begin
            acc_hit_q  <= acc_hit_d;
            acc_bad_q  <= acc_bad_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Press/release debounce FSM with registered key outputs and digit shifter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            digits_q    <= 16'h0000;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done) begin
                case (state_q)
                    S_IDLE: begin
                        if (scan_key) begin
                            cand_q  <= acc_code_d;
                            cnt_q   <= NW'(1);
                            state_q <= (DEBOUNCE_SCANS == 1) ? S_PRESSED : S_DEBOUNCE;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (scan_key && acc_code_d == cand_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == DEB_TARGET) begin
                                state_q <= S_PRESSED;
                            end
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                    S_PRESSED: begin
                        if (!scan_key) begin
                            cnt_q <= NW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state_q    <= S_IDLE;
                                key_held_q <= 1'b0;
                            end else begin
                                state_q    <= S_RELEASE;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (!scan_key) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == DEB_TARGET) begin
                                state_q    <= S_IDLE;
                                key_held_q <= 1'b0;
                            end
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_PRESSED;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
            if (do_accept) begin
                key_code_q  <= acc_code_d;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                digits_q    <= {digits_q[11:0], acc_code_d};
            end
        end
    end

    assign column    = column_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign digit_1   = digits_q[15:12];
    assign digit_2   = digits_q[11:8];
    assign digit_3   = digits_q[7:4];
    assign digit_4   = digits_q[3:0];

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scan-level reference model bench for keypad_scanner
module tb_keypad_scanner;

    localparam int SR   = 4;
    localparam int DS   = 2;
    localparam int SCAN = 4 * SR;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] column;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] digit_1, digit_2, digit_3, digit_4;

    // Keys currently held down, bit r*4+c.
    logic [15:0] keys = 16'h0000;

    int errors = 0;
    int checks = 0;

    // Reference model state: scan-level debounce.
    int         keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
    int         m_n;
    int         m_p;
    bit         m_held;
    logic [3:0] m_code;
    logic [3:0] m_dig [$];

    keypad_scanner #(.SCAN_RATIO(SR), .DEBOUNCE_SCANS(DS)) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .column    (column),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digit_1   (digit_1),
        .digit_2   (digit_2),
        .digit_3   (digit_3),
        .digit_4   (digit_4)
    );

    always #5 clock = ~clock;

    // Keypad physics: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !column[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_n    = 0;
        m_p    = 0;
        m_held = 0;
        m_code = 4'h0;
        m_dig  = '{4'h0, 4'h0, 4'h0, 4'h0};
    endfunction

    function automatic logic [15:0] model_digits();
        return {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
    endfunction

    // One full scan with a stable key set; returns whether a press is accepted.
    function automatic bit model_scan(input logic [15:0] mask);
        bit is_key;
        int k;
        is_key = ($countones(mask) == 1);
        k = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = keymap[i];
        if (!m_held) begin
            if (!is_key) m_n = 0;
            else if (m_n == 0) begin m_p = k; m_n = 1; end
            else if (k == m_p) m_n++;
            else m_n = 0;
            if (m_n == DS) begin
                m_n    = 0;
                m_held = 1;
                m_code = 4'(k);
                void'(m_dig.pop_front());
                m_dig.push_back(4'(k));
                return 1;
            end
        end else begin
            if (is_key) m_n = 0;
            else m_n++;
            if (m_n == DS) begin
                m_n    = 0;
                m_held = 0;
            end
        end
        return 0;
    endfunction

    // Caller sits 1ns after the edge that ends the previous scan.
    task automatic run_scan(input logic [15:0] mask);
        int stray;
        int col_bad;
        bit acc;
        stray   = 0;
        col_bad = 0;
        keys    = mask;
        acc     = model_scan(mask);
        for (int i = 1; i <= SCAN; i++) begin
            @(posedge clock);
            #1;
            if (i < SCAN && key_valid) stray++;
            if (column !== ~(4'b0001 << ((i / SR) % 4))) col_bad++;
        end
        check("key_valid", {31'd0, key_valid}, {31'd0, acc});
        check("stray_valid", stray, 0);
        check("column_seq", col_bad, 0);
        check("key_code", {28'd0, key_code}, {28'd0, m_code});
        check("key_held", {31'd0, key_held}, {31'd0, m_held});
        check("digits", {16'd0, digit_1, digit_2, digit_3, digit_4}, {16'd0, model_digits()});
    endtask

    task automatic hold(input logic [15:0] mask, input int scans);
        for (int s = 0; s < scans; s++) run_scan(mask);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_column"}, {28'd0, column}, 32'he);
        check({tag, "_outs"}, {25'd0, key_code, key_valid, key_held, 1'b0},  32'd0);
        check({tag, "_digits"}, {16'd0, digit_1, digit_2, digit_3, digit_4}, 32'd0);
    endtask

    // Assert reset asynchronously partway through a scan, then resume aligned.
    task automatic reset_mid(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clock);
        #1;
        keys  = 16'h0000;
        reset = 1'b0;
        model_reset();
        check_reset_outputs({tag, "_rel"});
    endtask

    initial begin
        logic [15:0] mask;
        int r1, r2;
        model_reset();
        // Power-on reset and column sequencing.
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        check_reset_outputs("por_rel");
        hold(16'h0000, 2);

        // Single press of 5, about 100 cycles, then release.
        hold(16'h0020, 7);
        hold(16'h0000, 3);

        // Sequence 1, 2, 3, A then 0.
        hold(16'h0001, 3); hold(16'h0000, 3);
        hold(16'h0002, 3); hold(16'h0000, 3);
        hold(16'h0004, 3); hold(16'h0000, 3);
        hold(16'h0008, 3); hold(16'h0000, 3);
        check("seq_digits", {16'd0, digit_1, digit_2, digit_3, digit_4}, 32'h123A);
        hold(16'h1000, 3); hold(16'h0000, 3);
        check("seq_fifth", {16'd0, digit_1, digit_2, digit_3, digit_4}, 32'h23A0);

        // Bounce: E for a single scan.
        hold(16'h4000, 1); hold(16'h0000, 3);

        // 1 and 6 together.
        hold(16'h0041, 3); hold(16'h0000, 3);

        // 7 held, then 9 added, then both released.
        hold(16'h0100, 3);
        hold(16'h0500, 3);
        hold(16'h0000, 3);
        check("seven_code", {28'd0, key_code}, 32'h7);

        // Reset during debounce, and during a held key.
        hold(16'h0020, 1);
        reset_mid("rst_deb", 6);
        hold(16'h0000, 1);
        hold(16'h0200, 3);
        reset_mid("rst_prs", 9);
        hold(16'h0000, 1);
        hold(16'h0800, 3); hold(16'h0000, 3);

        // Randomized key sets held for random scan counts.
        for (int e = 0; e < 40; e++) begin
            r1 = $urandom_range(0, 9);
            mask = 16'h0000;
            if (r1 < 6) mask[$urandom_range(0, 15)] = 1'b1;
            else if (r1 < 8) begin
                r2 = $urandom_range(0, 15);
                mask[r2] = 1'b1;
                mask[(r2 + $urandom_range(1, 15)) % 16] = 1'b1;
            end
            hold(mask, $urandom_range(1, 4));
        end
        hold(16'h0000, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
